// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: receives a 16-bit little-endian word count N and
// then N little-endian 32-bit words over a byte stream, and writes each word to
// instruction memory. Holds the CPU in reset until the load completes.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR check byte that is verified
// before the load is reported done.
// Latency: one WRITE cycle after every 4th data byte. byte_ready_o is low during
// WRITE, so the byte source is stalled rather than dropped.
module instr_mem_loader #(
  parameter int          WORDS     = 128,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wdata_o,
  output logic        cpu_rst_n_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] n_q;
  logic [15:0] idx_q;
  logic [1:0]  bcnt_q;
  logic [23:0] asm_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] len_full;
  logic        xfer;
  logic        restart;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign xfer     = byte_valid_i & byte_ready_o;
  assign len_full = {byte_data_i, n_q[7:0]};
  assign restart  = start_i & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));

  assign im_we_o     = (state_q == WRITE);
  assign im_addr_o   = addr_q;
  assign im_wdata_o  = wdata_q;
  assign cpu_rst_n_o = (state_q == DONE);
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERR);

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and byte-ready handshake
  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = LEN_LO;
      LEN_LO: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) state_d = LEN_HI;
      end
      LEN_HI: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          if (len_full == 16'd0)
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          else if ({16'd0, len_full} > 32'(WORDS)) state_d = ERR;
          else                                     state_d = DATA;
        end
      end
      DATA: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i && bcnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        if (idx_q + 16'd1 == n_q)
`ifdef LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        else
          state_d = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) state_d = (byte_data_i == csum_q) ? DONE : ERR;
      end
`endif
      DONE, ERR: if (start_i) state_d = LEN_LO;
      default: state_d = IDLE;
    endcase
  end

  // Length capture, word assembly, write address/data and word index
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= 16'd0;
      idx_q   <= 16'd0;
      bcnt_q  <= 2'd0;
      asm_q   <= 24'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      if (restart) begin
        n_q    <= 16'd0;
        idx_q  <= 16'd0;
        bcnt_q <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        csum_q <= 8'd0;
`endif
      end
      if (xfer) begin
        case (state_q)
          LEN_LO: n_q[7:0]  <= byte_data_i;
          LEN_HI: n_q[15:8] <= byte_data_i;
          DATA: begin
            bcnt_q <= bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data_i;
`endif
            case (bcnt_q)
              2'd0: asm_q[7:0]   <= byte_data_i;
              2'd1: asm_q[15:8]  <= byte_data_i;
              2'd2: asm_q[23:16] <= byte_data_i;
              default: begin
                wdata_q <= {byte_data_i, asm_q};
                addr_q  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state_q == WRITE) idx_q <= idx_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench for instr_mem_loader with a queue-based reference
// of the expected memory image; every comparison is an immediate assertion.
module tb_instr_mem_loader;
  localparam int WORDS = 128;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o, im_we_o, cpu_rst_n_o, done_o, err_o;
  logic [31:0] im_addr_o, im_wdata_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  payload[$];

  always #5 clk_i = ~clk_i;

  instr_mem_loader #(.WORDS(WORDS), .BASE_ADDR(32'd0)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .im_we_o(im_we_o),
    .im_addr_o(im_addr_o), .im_wdata_o(im_wdata_o),
    .cpu_rst_n_o(cpu_rst_n_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; the stream must be stalled while writing
  always @(negedge clk_i) begin
    if (im_we_o === 1'b1) begin
      wr_addr.push_back(im_addr_o);
      wr_data.push_back(im_wdata_o);
      check("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int  cnt = 0;
    logic got;
    if (gap) begin
      byte_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    forever begin
      @(negedge clk_i);
      got = byte_ready_o;
      @(posedge clk_i); #1;
      if (got === 1'b1) break;
      cnt++;
      if (cnt > 50) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_end();
    int cnt = 0;
    forever begin
      @(negedge clk_i);
      if (done_o === 1'b1 || err_o === 1'b1) break;
      cnt++;
      if (cnt > 20) begin
        check("end_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // One complete load: header, payload (if N is in range), optional check byte
  task automatic run_load(input string tag, input logic [15:0] n, input bit gaps,
                          input logic [7:0] csum_delta);
    bit          in_range;
    bit          exp_ok;
    int          exp_cnt;
    logic [7:0]  x;
    logic [31:0] exp_word;
    in_range = (int'(n) <= WORDS);
    exp_cnt  = in_range ? int'(n) : 0;
    x = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check({tag, "_ready_after_start"}, {31'd0, byte_ready_o}, 32'd1);
    check({tag, "_cpu_held_after_start"}, {31'd0, cpu_rst_n_o}, 32'd0);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    if (in_range) begin
      for (int i = 0; i < exp_cnt * 4; i++) begin
        send_byte(payload[i], gaps);
        x = x ^ payload[i];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (in_range) send_byte(x ^ csum_delta, gaps);
    exp_ok = in_range && (csum_delta == 8'h00);
`else
    exp_ok = in_range;
`endif
    wait_end();
    check({tag, "_done"}, {31'd0, done_o}, {31'd0, exp_ok});
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, !exp_ok});
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n_o}, {31'd0, exp_ok});
    check({tag, "_ready_idle"}, {31'd0, byte_ready_o}, 32'd0);
    check({tag, "_write_count"}, wr_addr.size(), exp_cnt);
    for (int i = 0; i < exp_cnt && i < wr_addr.size(); i++) begin
      exp_word = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
      check({tag, "_addr"}, wr_addr[i], 32'(4 * i));
      check({tag, "_wdata"}, wr_data[i], exp_word);
    end
    if (exp_cnt > 0) check({tag, "_addr_hold"}, im_addr_o, 32'(4 * (exp_cnt - 1)));
    @(posedge clk_i); #1;
  endtask

  task automatic fill_random(input int nbytes);
    payload.delete();
    for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_we", {31'd0, im_we_o}, 32'd0);
    check("rst_addr", im_addr_o, 32'd0);
    check("rst_wdata", im_wdata_o, 32'd0);
    check("rst_cpu", {31'd0, cpu_rst_n_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("idle_ready", {31'd0, byte_ready_o}, 32'd0);

    // Single word 0x20000013
    payload = '{8'h13, 8'h00, 8'h00, 8'h20};
    run_load("one_word", 16'd1, 1'b0, 8'h00);
    check("one_word_value", wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h2000_0013);

    // Two words with valid toggling
    fill_random(8);
    run_load("two_gap", 16'd2, 1'b1, 8'h00);

    // Empty load
    payload.delete();
    run_load("n_zero", 16'd0, 1'b0, 8'h00);

    // Oversize load, then restart from ERR
    payload.delete();
    run_load("n_129", 16'd129, 1'b0, 8'h00);
    pulse_start();
    check("err_restart_err", {31'd0, err_o}, 32'd0);
    check("err_restart_ready", {31'd0, byte_ready_o}, 32'd1);
    fill_random(12);
    run_load("after_err", 16'd3, 1'b0, 8'h00);

    // Reset in the middle of a word
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("midrst_we", {31'd0, im_we_o}, 32'd0);
    check("midrst_addr", im_addr_o, 32'd0);
    check("midrst_wdata", im_wdata_o, 32'd0);
    check("midrst_cpu", {31'd0, cpu_rst_n_o}, 32'd0);
    check("midrst_done_err", {30'd0, done_o, err_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("midrst_no_write", wr_addr.size(), 32'd0);
    check("midrst_idle_ready", {31'd0, byte_ready_o}, 32'd0);
    fill_random(8);
    run_load("after_rst", 16'd2, 1'b1, 8'h00);

    // Randomized loads
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(4 * n);
      run_load("rand", 16'(n), 1'($urandom), 8'h00);
    end

    // Capacity boundary
    fill_random(4 * WORDS);
    run_load("n_max", 16'(WORDS), 1'b0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    payload = '{8'h13, 8'h00, 8'h00, 8'h20};
    run_load("csum_bad", 16'd1, 1'b0, 8'h07);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
